// File: rtl/cnt_seq_ctrl.sv
// Command sequencer for the switch-loaded counter: synchronises and debounces the key,
// then issues a single load strobe and, while the key is held, gated auto-repeat increments.
module cnt_seq_ctrl #(
    parameter int W          = 10,
    parameter int DB_CYCLES  = 16,
    parameter int REP_DELAY  = 64,
    parameter int REP_PERIOD = 16,
    parameter int THRESH     = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] sw,
    input  logic         key_cmd,
    output logic         ld_stb,
    output logic [W-1:0] ld_data,
    output logic         inc_stb,
    output logic         event_o,
    output logic [2:0]   state_o
);

    localparam int PC_W    = $clog2(W + 1);
    localparam int DB_W    = $clog2(DB_CYCLES + 1);
    localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int TMR_W   = $clog2(REP_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DB_CYCLES - 1);
    localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REP_DELAY - 1);
    localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REP_PERIOD - 1);
    localparam logic [PC_W-1:0]  THRESH_C    = PC_W'(THRESH);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_ARM      = 3'd2;
    localparam logic [2:0] S_REPEAT   = 3'd3;
    localparam logic [2:0] S_WAIT_REL = 3'd4;

    logic             r_sync1;
    logic             r_key_s;
    logic [W-1:0]     r_sw_s;
    logic             r_event;
    logic             r_key_db;
    logic             r_key_db_d;
    logic [DB_W-1:0]  r_db_cnt;
    logic [2:0]       r_state;
    logic [TMR_W-1:0] r_timer;
    logic             r_ld_stb;
    logic             r_inc_stb;
    logic [W-1:0]     r_ld_data;

    logic [PC_W-1:0]  w_popcount;
    logic             w_press;
    logic             w_release;
    logic [2:0]       w_state_next;
    logic [TMR_W-1:0] w_timer_next;
    logic             w_ld_next;
    logic             w_inc_next;

    // The synchronizer keeps tracking the pin through reset, so a key held across
    // reset is already settled when the debouncer restarts from a cleared level.
    always_ff @(posedge clk) begin
        r_sync1 <= key_cmd;
        r_key_s <= r_sync1;
    end

    always_comb begin
        w_popcount = '0;
        for (int i = 0; i < W; i++) begin
            w_popcount = w_popcount + PC_W'(r_sw_s[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sw_s     <= '0;
            r_event    <= 1'b0;
            r_key_db   <= 1'b0;
            r_key_db_d <= 1'b0;
            r_db_cnt   <= '0;
        end else begin
            r_sw_s     <= sw;
            r_event    <= (w_popcount >= THRESH_C);
            r_key_db_d <= r_key_db;
            if (r_key_s != r_key_db) begin
                if (r_db_cnt == DB_LAST) begin
                    r_key_db <= r_key_s;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    assign w_press   = r_key_db & ~r_key_db_d;
    assign w_release = ~r_key_db;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_ld_stb  <= 1'b0;
            r_inc_stb <= 1'b0;
            r_ld_data <= '0;
        end else begin
            r_state   <= w_state_next;
            r_timer   <= w_timer_next;
            r_ld_stb  <= w_ld_next;
            r_inc_stb <= w_inc_next;
            if (w_ld_next) begin
                r_ld_data <= r_sw_s;
            end
        end
    end

    // Release has priority over an event drop; unused codes fall back to IDLE.
    always_comb begin
        w_state_next = r_state;
        w_timer_next = '0;
        case (r_state)
            S_IDLE: begin
                if (w_press) w_state_next = S_LOAD;
            end
            S_LOAD: begin
                w_state_next = r_event ? S_ARM : S_WAIT_REL;
            end
            S_ARM: begin
                w_timer_next = (r_timer == DELAY_LAST) ? '0 : r_timer + 1'b1;
                if (w_release)                  w_state_next = S_IDLE;
                else if (!r_event)              w_state_next = S_WAIT_REL;
                else if (r_timer == DELAY_LAST) w_state_next = S_REPEAT;
            end
            S_REPEAT: begin
                w_timer_next = (r_timer == PERIOD_LAST) ? '0 : r_timer + 1'b1;
                if (w_release)     w_state_next = S_IDLE;
                else if (!r_event) w_state_next = S_WAIT_REL;
            end
            S_WAIT_REL: begin
                if (w_release) w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_ld_next  = (r_state == S_LOAD);
        w_inc_next = r_key_db && r_event &&
                     (((r_state == S_ARM)    && (r_timer == DELAY_LAST)) ||
                      ((r_state == S_REPEAT) && (r_timer == PERIOD_LAST)));
    end

    assign ld_stb  = r_ld_stb;
    assign ld_data = r_ld_data;
    assign inc_stb = r_inc_stb;
    assign event_o = r_event;
    assign state_o = r_state;

endmodule
